mora_game_ctrl: RTL and testbench



---
 rtl/mora_pkg.sv | 86 ++++++++
 rtl/mora_game_ctrl_if.sv | 31 +++
 rtl/mora_tick_gen.sv | 24 ++
 rtl/mora_game_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_mora_game_ctrl.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mora_pkg.sv
// rtl/mora_pkg.sv - shared codes, glyph ROMs and helper functions for the mora game controller
// Glyph rows are active-low column patterns; row 0 sits in the most significant byte.
package mora_pkg;

    typedef enum logic [2:0] {
        ST_MORA  = 3'b100,
        ST_POINT = 3'b010,
        ST_SHOW  = 3'b011,
        ST_OVER  = 3'b001
    } state_e;

    localparam logic [2:0] G_ROCK     = 3'b100;
    localparam logic [2:0] G_SCISSORS = 3'b010;
    localparam logic [2:0] G_PAPER    = 3'b001;

    localparam logic [3:0] D_UP    = 4'b1000;
    localparam logic [3:0] D_DOWN  = 4'b0100;
    localparam logic [3:0] D_LEFT  = 4'b0010;
    localparam logic [3:0] D_RIGHT = 4'b0001;

    typedef enum logic [2:0] {
        GL_BLANK,
        GL_UP,
        GL_DOWN,
        GL_LEFT,
        GL_RIGHT,
        GL_V,
        GL_L
    } glyph_e;

    localparam logic [63:0] ROM_BLANK = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] ROM_UP    = 64'hE7C3_81E7_E7E7_E7FF;
    localparam logic [63:0] ROM_DOWN  = 64'hFFE7_E7E7_E781_C3E7;
    localparam logic [63:0] ROM_LEFT  = 64'hFFDF_9F01_019F_DFFF;
    localparam logic [63:0] ROM_RIGHT = 64'hFFFB_F980_80F9_FBFF;
    localparam logic [63:0] ROM_V     = 64'h7E7E_BDBD_DBDB_E7E7;
    localparam logic [63:0] ROM_L     = 64'hBFBF_BFBF_BFBF_81FF;

    function automatic logic [7:0] glyph_row(input glyph_e g, input logic [2:0] row);
        logic [63:0] bits;
        case (g)
            GL_UP:    bits = ROM_UP;
            GL_DOWN:  bits = ROM_DOWN;
            GL_LEFT:  bits = ROM_LEFT;
            GL_RIGHT: bits = ROM_RIGHT;
            GL_V:     bits = ROM_V;
            GL_L:     bits = ROM_L;
            default:  bits = ROM_BLANK;
        endcase
        return bits[{~row, 3'b000} +: 8];
    endfunction

    function automatic glyph_e dir_glyph(input logic [3:0] d);
        case (d)
            D_UP:    return GL_UP;
            D_DOWN:  return GL_DOWN;
            D_LEFT:  return GL_LEFT;
            D_RIGHT: return GL_RIGHT;
            default: return GL_BLANK;
        endcase
    endfunction

    // Non-one-hot gestures never match a legal code, so they never win.
    function automatic logic beats(input logic [2:0] a, input logic [2:0] b);
        return ((a == G_ROCK)     && (b == G_SCISSORS)) ||
               ((a == G_SCISSORS) && (b == G_PAPER))    ||
               ((a == G_PAPER)    && (b == G_ROCK));
    endfunction

    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        case (v)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

endpackage

// File: rtl/mora_game_ctrl_if.sv
// rtl/mora_game_ctrl_if.sv - player inputs and board outputs of the mora game controller
// master drives the player inputs; slave is the controller side.
interface mora_game_ctrl_if #(parameter int SCORE_W = 3);
    logic [2:0]         Left_mora;
    logic [2:0]         Right_mora;
    logic [3:0]         Left_direct;
    logic [3:0]         Right_direct;
    logic [7:0]         DATA_R;
    logic [7:0]         DATA_G;
    logic [7:0]         DATA_B;
    logic [3:0]         COMM;
    logic [6:0]         seg;
    logic [1:0]         COM;
    logic [SCORE_W-1:0] Left_score;
    logic [SCORE_W-1:0] Right_score;
    logic [2:0]         state;
    logic [1:0]         winner;
    logic [3:0]         rnd;

    modport master (
        output Left_mora, Right_mora, Left_direct, Right_direct,
        input  DATA_R, DATA_G, DATA_B, COMM, seg, COM,
        input  Left_score, Right_score, state, winner, rnd
    );

    modport slave (
        input  Left_mora, Right_mora, Left_direct, Right_direct,
        output DATA_R, DATA_G, DATA_B, COMM, seg, COM,
        output Left_score, Right_score, state, winner, rnd
    );
endinterface

// File: rtl/mora_tick_gen.sv
// rtl/mora_tick_gen.sv - free-running divider giving a one-cycle enable every DIV clocks
module mora_tick_gen #(
    parameter int DIV = 2
) (
    input  logic CLK,
    input  logic RST,
    output logic en
);
    localparam int              CW   = $clog2(DIV);
    localparam logic [CW-1:0]   LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge CLK) begin
        if (RST) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign en = (cnt_q == LAST);
endmodule

// File: rtl/mora_game_ctrl.sv
// rtl/mora_game_ctrl.sv - two-player mora / look-away game FSM with matrix and score scanning
// MORA_LFSR_EN selects an 8-bit LFSR defender direction instead of the plain rotation.
module mora_game_ctrl
    import mora_pkg::*;
#(
    parameter int TICK_DIV    = 25000000,
    parameter int SCAN_DIV    = 25000,
    parameter int SCORE_W     = 3,
    parameter int WIN_SCORE   = 7,
    parameter int POINT_TICKS = 3,
    parameter int SHOW_TICKS  = 2
) (
    input  logic              CLK,
    input  logic              RST,
    mora_game_ctrl_if.slave   io
);
    localparam logic [SCORE_W-1:0] WIN       = SCORE_W'(WIN_SCORE);
    localparam logic [7:0]         POINT_LIM = 8'(POINT_TICKS);
    localparam logic [7:0]         SHOW_LAST = 8'(SHOW_TICKS - 1);

    logic tick_en, scan_en;

    mora_tick_gen #(.DIV(TICK_DIV)) u_tick (.CLK(CLK), .RST(RST), .en(tick_en));
    mora_tick_gen #(.DIV(SCAN_DIV)) u_scan (.CLK(CLK), .RST(RST), .en(scan_en));

    state_e             state_q, state_d;
    logic               attacker_q, attacker_d;   // 1 = left attacks
    logic [3:0]         dir_q, dir_d;
    logic [7:0]         timeout_q, timeout_d;
    logic [7:0]         show_q, show_d;
    logic [SCORE_W-1:0] lscore_q, lscore_d;
    logic [SCORE_W-1:0] rscore_q, rscore_d;
    logic [1:0]         winner_q, winner_d;
    glyph_e             glyph_q, glyph_d;

    logic [2:0]         row_q, row_d;
    logic               com_sel_q, com_sel_d;
    logic [3:0]         comm_q, comm_d;
    logic [7:0]         data_g_q, data_g_d;
    logic [6:0]         seg_q, seg_d;
    logic [1:0]         com_q, com_d;
    logic [3:0]         rnd_q, rnd_d;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= ST_MORA;
            attacker_q <= 1'b0;
            dir_q      <= D_RIGHT;
            timeout_q  <= '0;
            show_q     <= '0;
            lscore_q   <= '0;
            rscore_q   <= '0;
            winner_q   <= 2'b00;
            glyph_q    <= GL_BLANK;
        end else begin
            state_q    <= state_d;
            attacker_q <= attacker_d;
            dir_q      <= dir_d;
            timeout_q  <= timeout_d;
            show_q     <= show_d;
            lscore_q   <= lscore_d;
            rscore_q   <= rscore_d;
            winner_q   <= winner_d;
            glyph_q    <= glyph_d;
        end
    end

    logic [3:0]         atk_dir;
    logic [SCORE_W-1:0] atk_new;

    always_comb begin
        state_d    = state_q;
        attacker_d = attacker_q;
        dir_d      = dir_q;
        timeout_d  = timeout_q;
        show_d     = show_q;
        lscore_d   = lscore_q;
        rscore_d   = rscore_q;
        winner_d   = winner_q;
        glyph_d    = glyph_q;
        atk_dir    = attacker_q ? io.Left_direct : io.Right_direct;
        atk_new    = (attacker_q ? lscore_q : rscore_q) + SCORE_W'(1);
        if (tick_en) begin
            case (state_q)
                ST_MORA: begin
                    if (beats(io.Left_mora, io.Right_mora) || beats(io.Right_mora, io.Left_mora)) begin
                        attacker_d = beats(io.Left_mora, io.Right_mora);
                        dir_d      = rnd_q;
                        timeout_d  = '0;
                        state_d    = ST_POINT;
                    end
                end
                ST_POINT: begin
                    if ($onehot(atk_dir)) begin
                        if (atk_dir == dir_q) begin
                            if (attacker_q) lscore_d = atk_new;
                            else            rscore_d = atk_new;
                            if (atk_new == WIN) begin
                                state_d  = ST_OVER;
                                winner_d = attacker_q ? 2'b10 : 2'b01;
                                glyph_d  = attacker_q ? GL_V : GL_L;
                            end else begin
                                state_d = ST_SHOW;
                                show_d  = '0;
                                glyph_d = dir_glyph(dir_q);
                            end
                        end else begin
                            state_d = ST_MORA;
                            glyph_d = GL_BLANK;
                        end
                    end else if (timeout_q + 8'd1 == POINT_LIM) begin
                        state_d = ST_MORA;
                        glyph_d = GL_BLANK;
                    end else begin
                        timeout_d = timeout_q + 8'd1;
                    end
                end
                ST_SHOW: begin
                    if (show_q == SHOW_LAST) begin
                        state_d = ST_MORA;
                        glyph_d = GL_BLANK;
                    end else begin
                        show_d = show_q + 8'd1;
                    end
                end
                ST_OVER: begin
                end
                default: state_d = ST_MORA;
            endcase
        end
    end

    always_comb begin
        io.state       = state_q;
        io.winner      = winner_q;
        io.Left_score  = lscore_q;
        io.Right_score = rscore_q;
        io.rnd         = rnd_q;
        io.DATA_R      = 8'hFF;
        io.DATA_B      = 8'hFF;
        io.DATA_G      = data_g_q;
        io.COMM        = comm_q;
        io.seg         = seg_q;
        io.COM         = com_q;
    end

`ifdef MORA_LFSR_EN
    logic [7:0] lfsr_q, lfsr_d;

    always_ff @(posedge CLK) begin
        if (RST) lfsr_q <= 8'h01;
        else     lfsr_q <= lfsr_d;
    end

    always_comb begin
        lfsr_d = lfsr_q;
        rnd_d  = rnd_q;
        if (scan_en) begin
            lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
            rnd_d  = D_UP >> lfsr_d[1:0];
        end
    end
`else
    always_comb begin
        rnd_d = rnd_q;
        if (scan_en) rnd_d = {rnd_q[2:0], rnd_q[3]};
    end
`endif

    // Scan outputs show the row/digit selected before this step, so row 0 appears first.
    always_comb begin
        row_d     = row_q;
        com_sel_d = com_sel_q;
        comm_d    = comm_q;
        data_g_d  = data_g_q;
        seg_d     = seg_q;
        com_d     = com_q;
        if (scan_en) begin
            comm_d    = {1'b1, row_q};
            data_g_d  = glyph_row(glyph_q, row_q);
            row_d     = row_q + 3'd1;
            com_d     = com_sel_q ? 2'b10 : 2'b01;
            seg_d     = seg_decode(com_sel_q ? 4'(rscore_q) : 4'(lscore_q));
            com_sel_d = ~com_sel_q;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            row_q     <= 3'd0;
            com_sel_q <= 1'b0;
            comm_q    <= 4'b1000;
            data_g_q  <= 8'hFF;
            seg_q     <= 7'b1000000;
            com_q     <= 2'b00;
            rnd_q     <= D_RIGHT;
        end else begin
            row_q     <= row_d;
            com_sel_q <= com_sel_d;
            comm_q    <= comm_d;
            data_g_q  <= data_g_d;
            seg_q     <= seg_d;
            com_q     <= com_d;
            rnd_q     <= rnd_d;
        end
    end
endmodule

// File: tb/tb_mora_game_ctrl.sv
// tb/tb_mora_game_ctrl.sv - directed self-checking bench for mora_game_ctrl
module tb_mora_game_ctrl;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    mora_game_ctrl_if #(.SCORE_W(3)) bus ();

    mora_game_ctrl #(
        .TICK_DIV(4), .SCAN_DIV(2), .SCORE_W(3), .WIN_SCORE(7),
        .POINT_TICKS(3), .SHOW_TICKS(2)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .io (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int ecount   = 0;
    int exp_l    = 0;
    int exp_r    = 0;

    logic [7:0] v_rows  [8] = '{8'h7E, 8'h7E, 8'hBD, 8'hBD, 8'hDB, 8'hDB, 8'hE7, 8'hE7};
    logic [7:0] up_rows [8] = '{8'hE7, 8'hC3, 8'h81, 8'hE7, 8'hE7, 8'hE7, 8'hE7, 8'hFF};
    logic [7:0] lf_rows [8] = '{8'hFF, 8'hDF, 8'h9F, 8'h01, 8'h01, 8'h9F, 8'hDF, 8'hFF};

    always @(posedge CLK) begin
        if (RST) ecount <= 0;
        else     ecount <= ecount + 1;
    end

    function automatic logic [3:0] exp_dir(input int k);
        return (k % 2 == 1) ? 4'b0010 : 4'b1000;
    endfunction

    function automatic logic [3:0] exp_rnd(input int k);
        logic [3:0] r;
        r = 4'b0001;
        for (int i = 0; i < (k / 2) % 4; i++) r = {r[2:0], r[3]};
        return r;
    endfunction

    function automatic logic [6:0] exp_seg(input int v);
        case (v)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic clear_inputs();
        bus.Left_mora = 3'b000; bus.Right_mora = 3'b000;
        bus.Left_direct = 4'b0000; bus.Right_direct = 4'b0000;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
    endtask

    task automatic wait_tick();
        for (int i = 0; i < 8; i++) begin
            @(posedge CLK); #1;
            if (ecount % 4 == 0) break;
        end
    endtask

    task automatic wait_scan();
        for (int i = 0; i < 4; i++) begin
            @(posedge CLK); #1;
            if (ecount % 2 == 0) break;
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        do_reset();
        n_checks++; if (bus.state !== 3'b100) $display("FAIL reset_state: got %b want 100", bus.state); else n_pass++;
        n_checks++; if (bus.Left_score !== 3'd0 || bus.Right_score !== 3'd0) $display("FAIL reset_scores: got %0d/%0d want 0/0", bus.Left_score, bus.Right_score); else n_pass++;
        n_checks++; if (bus.winner !== 2'b00) $display("FAIL reset_winner: got %b want 00", bus.winner); else n_pass++;
        n_checks++; if (bus.rnd !== 4'b0001) $display("FAIL reset_rnd: got %b want 0001", bus.rnd); else n_pass++;
        n_checks++; if (bus.DATA_G !== 8'hFF || bus.COMM !== 4'b1000) $display("FAIL reset_matrix: got %h/%b want FF/1000", bus.DATA_G, bus.COMM); else n_pass++;
        n_checks++; if (bus.seg !== 7'b1000000 || bus.COM !== 2'b00) $display("FAIL reset_seg: got %b/%b want 1000000/00", bus.seg, bus.COM); else n_pass++;
        n_checks++; if (bus.DATA_R !== 8'hFF || bus.DATA_B !== 8'hFF) $display("FAIL reset_rb: got %h/%h want FF/FF", bus.DATA_R, bus.DATA_B); else n_pass++;
    endtask

    task automatic test_rnd_scan();
        for (int i = 0; i < 6; i++) begin
            @(posedge CLK); #1;
            n_checks++; if (bus.rnd !== exp_rnd(ecount)) $display("FAIL rnd_rotate: edge %0d got %b want %b", ecount, bus.rnd, exp_rnd(ecount)); else n_pass++;
            if (ecount % 2 == 0) begin
                n_checks++; if (bus.COMM !== {1'b1, 3'((ecount / 2 - 1) % 8)} || bus.DATA_G !== 8'hFF) $display("FAIL scan_blank: edge %0d got %b/%h", ecount, bus.COMM, bus.DATA_G); else n_pass++;
            end
        end
    endtask

    task automatic test_left_hit();
        int k, r;
        logic [3:0] d;
        bus.Left_mora = 3'b100; bus.Right_mora = 3'b010;
        wait_tick();
        k = ecount / 4; d = exp_dir(k);
        n_checks++; if (bus.state !== 3'b010) $display("FAIL hit_point: got %b want 010", bus.state); else n_pass++;
        clear_inputs();
        bus.Left_direct = d; bus.Right_direct = 4'b0001;
        wait_tick();
        exp_l++;
        n_checks++; if (bus.Left_score !== 3'(exp_l) || bus.Right_score !== 3'(exp_r)) $display("FAIL hit_score: got %0d/%0d want %0d/%0d", bus.Left_score, bus.Right_score, exp_l, exp_r); else n_pass++;
        n_checks++; if (bus.state !== 3'b011) $display("FAIL hit_show: got %b want 011", bus.state); else n_pass++;
        clear_inputs();
        wait_scan();
        r = (ecount / 2 - 1) % 8;
        n_checks++; if (bus.DATA_G !== ((d == 4'b0010) ? lf_rows[r] : up_rows[r])) $display("FAIL hit_arrow: row %0d got %h", r, bus.DATA_G); else n_pass++;
        bus.Left_mora = 3'b100; bus.Right_mora = 3'b010;
        wait_tick();
        n_checks++; if (bus.state !== 3'b011) $display("FAIL show_hold: got %b want 011", bus.state); else n_pass++;
        wait_tick();
        clear_inputs();
        n_checks++; if (bus.state !== 3'b100) $display("FAIL show_end: got %b want 100", bus.state); else n_pass++;
    endtask

    task automatic test_timeout();
        int k;
        bus.Left_mora = 3'b100; bus.Right_mora = 3'b001;
        wait_tick();
        k = ecount / 4;
        n_checks++; if (bus.state !== 3'b010) $display("FAIL to_point: got %b want 010", bus.state); else n_pass++;
        clear_inputs();
        bus.Left_direct = exp_dir(k);
        wait_tick();
        wait_tick();
        n_checks++; if (bus.state !== 3'b010) $display("FAIL to_early: got %b want 010", bus.state); else n_pass++;
        wait_tick();
        n_checks++; if (bus.state !== 3'b100) $display("FAIL to_expire: got %b want 100", bus.state); else n_pass++;
        n_checks++; if (bus.Left_score !== 3'(exp_l) || bus.Right_score !== 3'(exp_r)) $display("FAIL to_score: got %0d/%0d want %0d/%0d", bus.Left_score, bus.Right_score, exp_l, exp_r); else n_pass++;
        clear_inputs();
    endtask

    task automatic test_miss();
        bus.Left_mora = 3'b010; bus.Right_mora = 3'b100;
        wait_tick();
        n_checks++; if (bus.state !== 3'b010) $display("FAIL miss_point: got %b want 010", bus.state); else n_pass++;
        clear_inputs();
        bus.Right_direct = 4'b0001;
        wait_tick();
        n_checks++; if (bus.state !== 3'b100 || bus.Right_score !== 3'(exp_r)) $display("FAIL miss: got %b/%0d want 100/%0d", bus.state, bus.Right_score, exp_r); else n_pass++;
        clear_inputs();
    endtask

    task automatic test_multihot_hit();
        int k;
        bus.Left_mora = 3'b100; bus.Right_mora = 3'b001;
        wait_tick();
        k = ecount / 4;
        clear_inputs();
        bus.Right_direct = 4'b1010;
        wait_tick();
        wait_tick();
        n_checks++; if (bus.state !== 3'b010) $display("FAIL mh_wait: got %b want 010", bus.state); else n_pass++;
        bus.Right_direct = exp_dir(k);
        wait_tick();
        exp_r++;
        n_checks++; if (bus.state !== 3'b011 || bus.Right_score !== 3'(exp_r)) $display("FAIL mh_hit: got %b/%0d want 011/%0d", bus.state, bus.Right_score, exp_r); else n_pass++;
        clear_inputs();
        wait_tick();
        wait_tick();
        n_checks++; if (bus.state !== 3'b100) $display("FAIL mh_back: got %b want 100", bus.state); else n_pass++;
    endtask

    task automatic test_tie();
        logic [2:0] lm [5] = '{3'b010, 3'b001, 3'b110, 3'b000, 3'b111};
        logic [2:0] rm [5] = '{3'b010, 3'b001, 3'b010, 3'b100, 3'b001};
        for (int i = 0; i < 5; i++) begin
            bus.Left_mora = lm[i]; bus.Right_mora = rm[i];
            wait_tick();
            n_checks++; if (bus.state !== 3'b100) $display("FAIL tie_%0d: got %b want 100", i, bus.state); else n_pass++;
        end
        clear_inputs();
    endtask

    task automatic play_round(input bit left_att);
        int k;
        bus.Left_mora = 3'b100;
        bus.Right_mora = left_att ? 3'b010 : 3'b001;
        wait_tick();
        k = ecount / 4;
        n_checks++; if (bus.state !== 3'b010) $display("FAIL round_point: got %b want 010", bus.state); else n_pass++;
        clear_inputs();
        if (left_att) bus.Left_direct = exp_dir(k);
        else          bus.Right_direct = exp_dir(k);
        wait_tick();
        if (left_att) exp_l++; else exp_r++;
        n_checks++; if (bus.Left_score !== 3'(exp_l) || bus.Right_score !== 3'(exp_r)) $display("FAIL round_score: got %0d/%0d want %0d/%0d", bus.Left_score, bus.Right_score, exp_l, exp_r); else n_pass++;
        clear_inputs();
        wait_tick();
        wait_tick();
        n_checks++; if (bus.state !== 3'b100) $display("FAIL round_end: got %b want 100", bus.state); else n_pass++;
    endtask

    task automatic test_seg_scan();
        int n;
        for (int i = 0; i < 8; i++) begin
            wait_scan();
            n = ecount / 2;
            n_checks++; if (bus.COM !== ((n % 2 == 1) ? 2'b01 : 2'b10)) $display("FAIL seg_com: step %0d got %b", n, bus.COM); else n_pass++;
            n_checks++; if (bus.seg !== ((n % 2 == 1) ? exp_seg(exp_l) : exp_seg(exp_r))) $display("FAIL seg_val: step %0d got %b", n, bus.seg); else n_pass++;
            n_checks++; if (bus.COMM !== {1'b1, 3'((n - 1) % 8)}) $display("FAIL seg_comm: step %0d got %b", n, bus.COMM); else n_pass++;
        end
    endtask

    task automatic test_win_over();
        int k, n;
        bus.Left_mora = 3'b100; bus.Right_mora = 3'b010;
        wait_tick();
        k = ecount / 4;
        clear_inputs();
        bus.Left_direct = exp_dir(k);
        wait_tick();
        exp_l++;
        n_checks++; if (bus.Left_score !== 3'd7 || bus.state !== 3'b001 || bus.winner !== 2'b10) $display("FAIL win: got %0d/%b/%b want 7/001/10", bus.Left_score, bus.state, bus.winner); else n_pass++;
        clear_inputs();
        for (int i = 0; i < 8; i++) begin
            wait_scan();
            n = ecount / 2;
            n_checks++; if (bus.DATA_G !== v_rows[(n - 1) % 8]) $display("FAIL win_v: row %0d got %h want %h", (n - 1) % 8, bus.DATA_G, v_rows[(n - 1) % 8]); else n_pass++;
        end
        bus.Left_mora = 3'b100; bus.Right_mora = 3'b001;
        bus.Left_direct = 4'b1000; bus.Right_direct = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            wait_tick();
            n_checks++; if (bus.state !== 3'b001 || bus.Left_score !== 3'd7 || bus.Right_score !== 3'(exp_r) || bus.winner !== 2'b10) $display("FAIL over_hold: got %b %0d/%0d %b", bus.state, bus.Left_score, bus.Right_score, bus.winner); else n_pass++;
        end
        clear_inputs();
    endtask

    task automatic test_reset_from_over();
        do_reset();
        exp_l = 0; exp_r = 0;
        n_checks++; if (bus.state !== 3'b100 || bus.winner !== 2'b00 || bus.Left_score !== 3'd0 || bus.DATA_G !== 8'hFF) $display("FAIL rst_over: got %b %b %0d %h", bus.state, bus.winner, bus.Left_score, bus.DATA_G); else n_pass++;
    endtask

    task automatic test_reset_mid_point();
        play_round(1'b1);
        bus.Left_mora = 3'b100; bus.Right_mora = 3'b010;
        wait_tick();
        n_checks++; if (bus.state !== 3'b010) $display("FAIL rmp_point: got %b want 010", bus.state); else n_pass++;
        clear_inputs();
        @(posedge CLK); #1;
        do_reset();
        exp_l = 0;
        n_checks++; if (bus.state !== 3'b100 || bus.Left_score !== 3'd0 || bus.Right_score !== 3'd0) $display("FAIL rmp_state: got %b %0d/%0d want 100 0/0", bus.state, bus.Left_score, bus.Right_score); else n_pass++;
        n_checks++; if (bus.rnd !== 4'b0001 || bus.DATA_G !== 8'hFF || bus.COMM !== 4'b1000) $display("FAIL rmp_disp: got %b %h %b want 0001 FF 1000", bus.rnd, bus.DATA_G, bus.COMM); else n_pass++;
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_rnd_scan();
        test_left_hit();
        test_timeout();
        test_miss();
        test_multihot_hit();
        test_tie();
        play_round(1'b1);
        play_round(1'b1);
        for (int i = 0; i < 4; i++) play_round(1'b0);
        test_seg_scan();
        for (int i = 0; i < 3; i++) play_round(1'b1);
        test_win_over();
        test_reset_from_over();
        test_reset_mid_point();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
